// File: rtl/demux_scan_ctrl.sv
// Sequencer for the 1-to-16 demux tree: latches a 16-bit word and walks the
// select across channels 0..15, holding each channel for DWELL cycles.
module demux_scan_ctrl #(
   parameter int unsigned DWELL = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        abort,
   output logic        a,
   output logic [3:0]  s,
   output logic        en,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

   state_t      state, state_nxt;
   logic [15:0] word, word_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic [3:0]  s_nxt;
   logic [3:0]  s_inc;
   logic        a_nxt;
   logic        en_nxt;
   logic        done_nxt;
   logic        dwell_end;

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign dwell_end = (cnt == DWELL_LAST);
   assign s_inc     = s + 4'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         word  <= '0;
         cnt   <= '0;
         s     <= '0;
         a     <= 1'b0;
         en    <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         word  <= word_nxt;
         cnt   <= cnt_nxt;
         s     <= s_nxt;
         a     <= a_nxt;
         en    <= en_nxt;
         done  <= done_nxt;
      end
   end

   // Outputs are registered: the next-cycle values are decided here together
   // with the next state, so a/s/en/done line up with the state they describe.
   always_comb begin
      state_nxt = state;
      word_nxt  = word;
      cnt_nxt   = cnt;
      s_nxt     = s;
      a_nxt     = a;
      en_nxt    = en;
      done_nxt  = 1'b0;

      unique case (state)
         IDLE: begin
            s_nxt  = '0;
            a_nxt  = 1'b0;
            en_nxt = 1'b0;
            if (in_valid) begin
               state_nxt = SCAN;
               word_nxt  = in_data;
               cnt_nxt   = '0;
               a_nxt     = in_data[0];
               en_nxt    = 1'b1;
            end
         end

         SCAN: begin
            if (abort) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               s_nxt     = '0;
               a_nxt     = 1'b0;
               en_nxt    = 1'b0;
            end else if (dwell_end) begin
               cnt_nxt = '0;
               if (s == 4'd15) begin
                  state_nxt = DONE;
                  s_nxt     = '0;
                  a_nxt     = 1'b0;
                  en_nxt    = 1'b0;
                  done_nxt  = 1'b1;
               end else begin
                  s_nxt = s_inc;
                  a_nxt = word[s_inc];
               end
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end

         DONE: begin
            state_nxt = IDLE;
            s_nxt     = '0;
            a_nxt     = 1'b0;
            en_nxt    = 1'b0;
         end

         default: begin
            state_nxt = IDLE;
            s_nxt     = '0;
            a_nxt     = 1'b0;
            en_nxt    = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Scoreboard bench for demux_scan_ctrl with DWELL=1 and DWELL=3 instances.
module tb_demux_scan_ctrl;

   logic        clk;
   logic        rst;
   logic [15:0] in_data  [2];
   logic        in_valid [2];
   logic        abort    [2];
   logic        in_ready [2];
   logic        a        [2];
   logic [3:0]  s        [2];
   logic        en       [2];
   logic        busy     [2];
   logic        done     [2];

   demux_scan_ctrl #(.DWELL(1)) dut1 (
      .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
      .in_ready(in_ready[0]), .abort(abort[0]), .a(a[0]), .s(s[0]),
      .en(en[0]), .busy(busy[0]), .done(done[0])
   );

   demux_scan_ctrl #(.DWELL(3)) dut3 (
      .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
      .in_ready(in_ready[1]), .abort(abort[1]), .a(a[1]), .s(s[1]),
      .en(en[1]), .busy(busy[1]), .done(done[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Packed view {en, s, a, done, in_ready, busy}
   localparam logic [8:0] IDLE_V = 9'b0_0000_0_0_1_0;

   typedef struct {
      int         idx;
      logic [8:0] v;
   } exp_t;

   exp_t sb[$];

   int n_chk     = 0;
   int n_pass    = 0;
   int timeouts  = 0;
   bit end_req   = 1'b0;
   bit mon_done  = 1'b0;

   function automatic logic [8:0] obs(input int i);
      return {en[i], s[i], a[i], done[i], in_ready[i], busy[i]};
   endfunction

   task automatic chk(input string nm, input int i, input logic [8:0] got,
                      input logic [8:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s inst%0d @%0t: got %b want %b (en,s,a,done,rdy,busy)",
                    nm, i, $time, got, want);
   endtask

   // Reference model: a scan is 16*D cycles indexed by t; channel = t / D.
   int         m_mode [2];   // 0 idle, 1 scanning, 2 done
   int         m_t    [2];
   logic [15:0] m_w   [2];

   always @(posedge clk or posedge rst) begin : model
      exp_t e;
      int   d;
      int   ch;
      if (rst) begin
         sb.delete();
         for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;
            m_t[i]    = 0;
            m_w[i]    = '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            d = (i == 0) ? 1 : 3;
            case (m_mode[i])
               0: if (in_valid[i]) begin
                     m_mode[i] = 1;
                     m_t[i]    = 0;
                     m_w[i]    = in_data[i];
                  end
               1: if (abort[i]) m_mode[i] = 0;
                  else if (m_t[i] == 16 * d - 1) m_mode[i] = 2;
                  else m_t[i] = m_t[i] + 1;
               default: m_mode[i] = 0;
            endcase
            e.idx = i;
            case (m_mode[i])
               1: begin
                  ch  = m_t[i] / d;
                  e.v = {1'b1, 4'(ch), m_w[i][ch], 1'b0, 1'b0, 1'b1};
               end
               2:       e.v = 9'b0_0000_0_1_0_1;
               default: e.v = IDLE_V;
            endcase
            sb.push_back(e);
         end
      end
   end

   always @(negedge clk or posedge rst) begin : monitor
      exp_t e;
      if (rst) begin
         #1;
         for (int i = 0; i < 2; i++) chk("reset", i, obs(i), IDLE_V);
      end else begin
         while (sb.size() > 0) begin
            e = sb.pop_front();
            chk("cycle", e.idx, obs(e.idx), e.v);
         end
         if (end_req && !mon_done) begin
            chk("drv_timeouts", 0, 9'(timeouts), 9'd0);
            mon_done = 1'b1;
         end
      end
   end

   // Called at a negedge; returns at the negedge after the handshake edge
   // with in_valid still high.
   task automatic send(input int i, input logic [15:0] w);
      bit ok = 1'b0;
      in_valid[i] = 1'b1;
      in_data[i]  = w;
      for (int n = 0; n < 200 && !ok; n++) begin
         ok = in_ready[i];
         @(posedge clk);
         @(negedge clk);
      end
      if (!ok) timeouts++;
   endtask

   task automatic wait_s(input int i, input logic [3:0] v);
      bit ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
         if (en[i] && s[i] == v) ok = 1'b1;
         else @(negedge clk);
      end
      if (!ok) timeouts++;
   endtask

   task automatic wait_idle(input int i);
      bit ok = 1'b0;
      in_valid[i] = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
         if (in_ready[i]) ok = 1'b1;
         else @(negedge clk);
      end
      if (!ok) timeouts++;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      #3 rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int k;
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid[i] = 1'b0;
         in_data[i]  = '0;
         abort[i]    = 1'b0;
      end
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      #3 rst = 1'b0;
      repeat (5) @(negedge clk);

      // Pattern scans on both dwell settings
      send(0, 16'hA5C3);
      wait_idle(0);
      send(1, 16'h0001);
      wait_idle(1);

      // Back-to-back words with in_valid held high
      send(0, 16'hFFFF);
      send(0, 16'h0000);
      wait_idle(0);

      // Input noise during a scan, then abort at channel 7
      send(0, 16'h5A3C);
      for (int n = 0; n < 40; n++) begin
         if (en[0] && s[0] == 4'd7) break;
         in_valid[0] = 1'($urandom);
         in_data[0]  = 16'($urandom);
         @(negedge clk);
      end
      wait_s(0, 4'd7);
      in_valid[0] = 1'b0;
      abort[0]    = 1'b1;
      @(negedge clk);
      abort[0]    = 1'b0;
      repeat (4) @(negedge clk);

      // Asynchronous reset at channel 9, then a normal scan
      send(0, 16'hFFFF);
      in_valid[0] = 1'b0;
      wait_s(0, 4'd9);
      do_reset();
      send(0, 16'h8000);
      wait_idle(0);
      send(1, 16'hC00F);
      in_valid[1] = 1'b0;
      wait_s(1, 4'd4);
      do_reset();

      // Randomised words, noise and aborts (abort may land in any state)
      repeat (24) begin
         k = int'($urandom_range(0, 1));
         send(k, 16'($urandom));
         in_valid[k] = 1'b0;
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(0, 50)) begin
               in_valid[k] = 1'($urandom);
               in_data[k]  = 16'($urandom);
               @(negedge clk);
            end
            in_valid[k] = 1'b0;
            abort[k]    = 1'b1;
            @(negedge clk);
            abort[k]    = 1'b0;
         end
         wait_idle(k);
      end

      repeat (3) @(negedge clk);
      end_req = 1'b1;
      for (int n = 0; n < 10 && !mon_done; n++) @(negedge clk);
      if (!mon_done) begin
         n_chk++;
         $display("FAIL monitor_end: got no final check, want final check");
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/demux_scan_ctrl.md
# demux_scan_ctrl

Upstream sequencer for the 1-to-16 demultiplexer tree. It accepts a 16-bit word through a valid/ready handshake and walks the demux select from channel 0 to channel 15. At each channel it presents the matching word bit on the demux data input. Each channel is held for a programmable dwell time, after which the block pulses `done` and returns to idle for the next word.

## Interface
- `DWELL`, default 1: cycles each channel is held. Legal range 1..255. Dwell counter is 8 bits.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_data`  in  16  word to scan out; bit i goes to channel i.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word.
- `abort`  in  1  synchronous cancel of a scan in progress.
- `a`  out  1  data bit to the demux data input.
- `s`  out  4  channel select to the demux.
- `en`  out  1  high while `a`/`s` carry a live channel.
- `busy`  out  1  high in SCAN and DONE.
- `done`  out  1  one-cycle pulse after channel 15 completes.

## Operation
- States:
  - IDLE: `in_ready`=1, `en`=0, `a`=0, `s`=0.
  - SCAN: `en`=1, `a`=word[`s`].
  - DONE: `done`=1, `en`=0, `a`=0, `in_ready`=0.
- IDLE -> SCAN when `in_valid`=1 (handshake).
  - Latch `in_data` into the internal word register.
  - Clear `s` and the dwell counter.
- SCAN, per cycle:
  - Dwell counter increments.
  - When the counter equals `DWELL`-1, the counter clears and `s` advances.
  - If `s` is 15 when the counter equals `DWELL`-1, go to DONE instead of advancing.
- DONE -> IDLE unconditionally after one cycle.
- `abort`=1 in SCAN:
  - Next state is IDLE; no `done` pulse.
  - `en`, `a` and `s` are 0 from the next cycle.
  - `abort` is ignored in IDLE and DONE.
- `abort` and end-of-scan in the same cycle: `abort` wins, so no DONE.
- `in_valid` outside IDLE is ignored. The word is not latched, and upstream must hold it until `in_ready`.
- `a` is gated by `en`, so an idle demux drives all 16 outputs to 0.
- `busy` = (state != IDLE). `in_ready` = (state == IDLE), decoded from state.
- `s` wraps only via DONE/IDLE. It never counts past 15 or wraps to 0 inside SCAN.

## Timing
- Reset values:
  - State IDLE.
  - `a`=0, `s`=0, `en`=0, `busy`=0, `done`=0.
  - `in_ready`=1.
  - Word register 0, dwell counter 0.
- Reset asserted mid-scan: all of the above take effect immediately (asynchronous). The scan is lost and no `done` is produced.
- `a`, `s`, `en`, `done` are registered outputs.
- Handshake at edge k:
  - `en`=1, `s`=0, `a`=word[0] from edge k+1.
  - Channel n is held for edges k+1+n·DWELL through k+(n+1)·DWELL.
- DONE (`done`=1) occupies the cycle after channel 15's last dwell cycle. `in_ready` returns the cycle after that.
- Throughput: one word per 16·DWELL+2 cycles when `in_valid` is held high.

## Test plan
- Reset values:
  - Assert `rst` asynchronously mid-cycle: `in_ready`=1 and `a`/`s`/`en`/`done`/`busy`=0 at once, without waiting for a clock edge.
  - After release, no activity until `in_valid`.
- `DWELL`=1, `in_data`=16'hA5C3:
  - Over 16 cycles `s`=0..15 with `a` = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 and `en`=1.
  - Then `done`=1 for exactly 1 cycle, then `in_ready`=1.
- `DWELL`=3, `in_data`=16'h0001:
  - `a`=1 for 3 cycles with `s`=0, then `a`=0 for 45 cycles.
  - Each `s` value is held for 3 cycles; `done` arrives 49 cycles after the handshake.
- Back-to-back words 16'hFFFF then 16'h0000 with `in_valid` held high:
  - Second handshake occurs in the IDLE cycle after `done`.
  - Words a`DWELL`=1 period of 18 cycles apart.
  - Channel values are never mixed between the two words.
- Abort and ignored input, `DWELL`=1:
  - Assert `abort` when `s`=7: next cycle `en`=0, `s`=0, `a`=0, `in_ready`=1, and `done` never pulses.
  - `in_valid`/`in_data` changes during SCAN do not alter `a`.
- `rst` pulse while `s`=9:
  - Outputs clear immediately.
  - A new word 16'h8000 is then scanned normally, with `a`=1 only at `s`=15.
